uart_mmio_tx: RTL and testbench

- MMIO-driven UART transmitter. It is the outbound counterpart of the UART programmer/receiver path and sits on the core's memory-stage MMIO write port (mmio_wea/mmio_dat).
- CPU stores push bytes into a small FIFO. A baud-timed serializer drives the tx pin as 8N1 frames, LSB first.
- Status outputs and a completion interrupt feed the core's uart_IRQ/trap logic.

---
 rtl/uart_mmio_tx_if.sv | 13 +
 rtl/uart_mmio_tx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_mmio_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_tx_if.sv
// MMIO write-port bundle between the core's memory stage and the UART transmitter.
//   mmio_wea  : write strobe, one byte per asserted cycle
//   mmio_dat  : write data, only [7:0] carries the byte
//   mmio_read : transmitter ready (FIFO not full)
`timescale 1ns/1ps
interface uart_mmio_tx_if;
  logic        mmio_wea;
  logic [31:0] mmio_dat;
  logic        mmio_read;

  modport master (output mmio_wea, output mmio_dat, input mmio_read);
  modport slave  (input mmio_wea, input mmio_dat, output mmio_read);
endinterface

// File: rtl/uart_mmio_tx.sv
// MMIO-driven UART transmitter: CPU stores fill a byte FIFO, a baud-timed
// serializer sends 8N1 frames LSB first on tx.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (parameter PARITY_ODD).
// Ports:
//   clk       : system clock
//   Rst       : synchronous reset, active-high
//   mmio      : MMIO write port (mmio_wea, mmio_dat in; mmio_read out = FIFO not full)
//   tx        : serial line, idle high, registered
//   tx_busy   : frame on the line or FIFO non-empty
//   tx_ovf    : sticky overflow flag, cleared only by Rst
//   tx_IRQ    : one-cycle pulse when the last queued frame completes
`timescale 1ns/1ps
module uart_mmio_tx #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 16
`ifdef UART_TX_PARITY_EN
  , parameter bit        PARITY_ODD = 1'b0
`endif
) (
  input  logic          clk,
  input  logic          Rst,
  uart_mmio_tx_if.slave mmio,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_ovf,
  output logic          tx_IRQ
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_nxt;
  logic [7:0]        shift_q;
  logic [7:0]        shift_nxt;
  logic              tx_nxt;
  logic              irq_nxt;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
  logic              par_nxt;
`endif

  logic              push_c;
  logic              pop_c;
  logic              bit_end_c;
  logic              fifo_empty_c;
  logic              unused_dat_c;

  // Fullness is judged on the registered count, so a pop in the same cycle cannot make room.
  assign push_c       = mmio.mmio_wea && (count != FULL_CNT);
  assign fifo_empty_c = (count == '0);
  assign bit_end_c    = (baud_cnt == BAUD_LAST);
  assign unused_dat_c = ^mmio.mmio_dat[31:8];

  assign mmio.mmio_read = (count != FULL_CNT);
  assign tx_busy        = (state != IDLE) || !fifo_empty_c;

  // State register.
  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, serializer datapath and line level; tx lags the state by one cycle.
  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift_q;
    tx_nxt    = 1'b1;
    irq_nxt   = 1'b0;
    pop_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif

    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty_c) begin
          pop_c     = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end_c) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        tx_nxt = shift_q[0];
        if (bit_end_c) begin
          shift_nxt = {1'b0, shift_q[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = par_q;
        if (bit_end_c) state_nxt = STOP;
      end
`endif
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end_c) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty_c) begin
            pop_c     = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
            irq_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (pop_c) begin
      shift_nxt = fifo_mem[rd_ptr];
      baud_nxt  = '0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = (^fifo_mem[rd_ptr]) ^ PARITY_ODD;
`endif
    end
  end

  // Serializer registers and outputs.
  always_ff @(posedge clk) begin
    if (Rst) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift_q  <= 8'd0;
      tx       <= 1'b1;
      tx_IRQ   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift_q  <= shift_nxt;
      tx       <= tx_nxt;
      tx_IRQ   <= irq_nxt;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_nxt;
`endif
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mmio.mmio_wea && !push_c) tx_ovf <= 1'b1;
    end
  end

  // FIFO storage; stale contents are harmless because the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= mmio.mmio_dat[7:0];
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Scoreboarded bench for uart_mmio_tx: stimulus queues expected bytes, a line
// monitor decodes tx frames and compares them, an IRQ monitor tracks pulses.
`timescale 1ns/1ps
module tb_uart_mmio_tx;
  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS   = 11;
  localparam bit          PAR_ODD = 1'b0;
`else
  localparam int unsigned NBITS   = 10;
`endif
  localparam int unsigned FRAME_CYC = NBITS * BAUD;

  logic clk = 1'b0;
  logic Rst;
  logic tx, tx_busy, tx_ovf, tx_IRQ;

  uart_mmio_tx_if bus();

  uart_mmio_tx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD (PAR_ODD)
`endif
  ) dut (
    .clk     (clk),
    .Rst     (Rst),
    .mmio    (bus),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_ovf  (tx_ovf),
    .tx_IRQ  (tx_IRQ)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks    = 0;
  int         errors    = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] bq[$];
  logic       exp_ovf   = 1'b0;
  logic       in_frame  = 1'b0;
  int         irq_count = 0;
  int         irq_cyc   = -1;
  int         irq_mark  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal line waveform of one frame, one sample per clock.
  function automatic logic [63:0] wave_of(input logic [7:0] b);
    logic [NBITS-1:0] bits;
    logic [63:0]      w;
    w       = '0;
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = (^b) ^ PAR_ODD;
`endif
    bits[NBITS-1] = 1'b1;
    for (int s = 0; s < int'(FRAME_CYC); s++) w[s] = bits[s / int'(BAUD)];
    return w;
  endfunction

  // Line monitor: decode frames from tx and score against the expected queue.
  initial begin : line_mon
    logic        prev_tx;
    logic        aborted;
    logic [63:0] fr;
    logic [7:0]  eb;
    int          s_cyc;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (Rst) begin
        prev_tx = 1'b1;
        continue;
      end
      if (prev_tx && !tx) begin
        in_frame = 1'b1;
        s_cyc    = cyc;
        fr       = '0;
        fr[0]    = tx;
        aborted  = 1'b0;
        for (int s = 1; s < int'(FRAME_CYC); s++) begin
          @(negedge clk);
          if (Rst) begin
            aborted = 1'b1;
            break;
          end
          fr[s] = tx;
        end
        in_frame = 1'b0;
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(s_cyc), 64'hFFFF_FFFF);
          end else begin
            eb = exp_q.pop_front();
            check("frame_wave", fr, wave_of(eb));
            start_q.push_back(s_cyc);
          end
          prev_tx = fr[FRAME_CYC-1];
        end else begin
          prev_tx = 1'b1;
        end
      end else begin
        prev_tx = tx;
      end
    end
  end

  // IRQ monitor: single-cycle pulses only, and the transmitter must be idle.
  initial begin : irq_mon
    logic prev_irq;
    prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_IRQ === 1'b1) begin
        irq_count++;
        irq_cyc = cyc;
        check("irq_busy_low", 64'(tx_busy), 64'd0);
        check("irq_single", 64'(prev_irq), 64'd0);
      end
      prev_irq = (tx_IRQ === 1'b1);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write the bytes in bq on consecutive cycles into an idle transmitter.
  // Model: first byte is popped on the following edge; pushes need count < DEPTH.
  task automatic burst(output int n0, output int acc);
    int   cnt;
    int   k;
    logic ok;
    cnt = 0;
    acc = 0;
    n0  = 0;
    k   = bq.size();
    for (int i = 0; i < k; i++) begin
      bus.mmio_wea = 1'b1;
      bus.mmio_dat = ($urandom() & 32'hFFFF_FF00) | 32'(bq[i]);
      ok = (cnt < int'(DEPTH));
      step(1);
      if (i == 0) n0 = cyc;
      if (ok) begin
        exp_q.push_back(bq[i]);
        acc++;
      end else begin
        exp_ovf = 1'b1;
      end
      cnt = cnt + (ok ? 1 : 0) - ((i == 1) ? 1 : 0);
      check("mmio_read", 64'(bus.mmio_read), 64'(cnt != int'(DEPTH)));
    end
    bus.mmio_wea = 1'b0;
    bq.delete();
  endtask

  task automatic wait_drain();
    int budget;
    budget = int'(FRAME_CYC) * (int'(DEPTH) + 3) + 50;
    while (budget > 0 && (exp_q.size() != 0 || in_frame)) begin
      step(1);
      budget--;
    end
    if (budget == 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    step(4);
  endtask

  // After a burst: frames back to back from the expected first start, one IRQ at the end.
  task automatic finish_burst(input int n0, input int acc);
    wait_drain();
    check("frame_count", 64'(start_q.size()), 64'(acc));
    if (start_q.size() == acc && acc > 0) begin
      check("first_start", 64'(start_q[0]), 64'(n0 + 2));
      for (int i = 1; i < acc; i++)
        check("frame_gap", 64'(start_q[i] - start_q[i-1]), 64'(FRAME_CYC));
      check("irq_cycle", 64'(irq_cyc), 64'(start_q[acc-1] + int'(FRAME_CYC) - 1));
    end
    check("irq_pulses", 64'(irq_count - irq_mark), 64'd1);
    check("tx_ovf", 64'(tx_ovf), 64'(exp_ovf));
    check("idle_busy", 64'(tx_busy), 64'd0);
    check("idle_tx", 64'(tx), 64'd1);
    start_q.delete();
    irq_mark = irq_count;
  endtask

  initial begin : stim
    int n0;
    int acc;
    int k;
    Rst          = 1'b1;
    bus.mmio_wea = 1'b0;
    bus.mmio_dat = 32'd0;
    step(3);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_read", 64'(bus.mmio_read), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_ovf", 64'(tx_ovf), 64'd0);
    check("rst_irq", 64'(tx_IRQ), 64'd0);
    Rst = 1'b0;
    step(3);

    // Single byte 0x55, then 0x07 (parity-sensitive pattern).
    bq.push_back(8'h55);
    burst(n0, acc);
    finish_burst(n0, acc);
    bq.push_back(8'h07);
    burst(n0, acc);
    finish_burst(n0, acc);

    // Back-to-back pair.
    bq.push_back(8'h41);
    bq.push_back(8'h42);
    burst(n0, acc);
    finish_burst(n0, acc);

    // Six writes: five accepted, sixth dropped and flags overflow.
    for (int i = 0; i < 6; i++) bq.push_back(8'(8'hA0 + i));
    burst(n0, acc);
    check("ovf_accepted", 64'(acc), 64'(DEPTH + 1));
    finish_burst(n0, acc);

    // Push coinciding with the pop at the end of the first stop bit.
    bq.push_back(8'h11);
    bq.push_back(8'h22);
    bq.push_back(8'h33);
    burst(n0, acc);
    while (cyc < n0 + int'(FRAME_CYC)) step(1);
    bus.mmio_wea = 1'b1;
    bus.mmio_dat = 32'h0000_0044;
    step(1);
    bus.mmio_wea = 1'b0;
    exp_q.push_back(8'h44);
    acc++;
    check("pushpop_count", 64'(dut.count), 64'd2);
    check("pushpop_read", 64'(bus.mmio_read), 64'd1);
    finish_burst(n0, acc);

    // Randomized bursts with idle gaps.
    for (int r = 0; r < 10; r++) begin
      step($urandom_range(0, 20));
      k = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < k; i++) bq.push_back(8'($urandom()));
      burst(n0, acc);
      finish_burst(n0, acc);
    end

    // Reset during data bit 3 with three bytes still queued.
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom()));
    burst(n0, acc);
    while (cyc < n0 + 2 + 4 + 13) step(1);
    Rst = 1'b1;
    step(1);
    check("midrst_tx", 64'(tx), 64'd1);
    check("midrst_read", 64'(bus.mmio_read), 64'd1);
    check("midrst_busy", 64'(tx_busy), 64'd0);
    check("midrst_ovf", 64'(tx_ovf), 64'd0);
    check("midrst_irq", 64'(tx_IRQ), 64'd0);
    Rst = 1'b0;
    exp_q.delete();
    exp_ovf  = 1'b0;
    irq_mark = irq_count;
    step(200);
    check("midrst_frames", 64'(start_q.size()), 64'd0);
    check("midrst_no_irq", 64'(irq_count - irq_mark), 64'd0);
    check("midrst_count", 64'(dut.count), 64'd0);
    check("midrst_idle_tx", 64'(tx), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
